// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing, sync/bright and per-frame game tick.
// Define VGA_PIPE_ALIGN_EN to delay hSync/vSync/bright by one extra pixel.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 783,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 514,
  parameter int TICK_FRAMES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic       game_tick,
  output logic       game_clk
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE = DW'(CLK_DIV - 2);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS = 10'(H_SYNC);
  localparam logic [9:0] VS = 10'(V_SYNC);
  localparam logic [9:0] HDS = 10'(H_DISP_START);
  localparam logic [9:0] HDE = 10'(H_DISP_END);
  localparam logic [9:0] VDS = 10'(V_DISP_START);
  localparam logic [9:0] VDE = 10'(V_DISP_END);
  localparam logic [7:0] TF_LAST = 8'(TICK_FRAMES - 1);
  logic [DW-1:0] div_cnt;
  logic [7:0] frame_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic h_end, v_end, wrap, hs, vs, br;
  always_comb begin
    h_end = hCount == H_LAST;
    v_end = vCount == V_LAST;
    wrap = pix_en && h_end && v_end;
    h_nxt = h_end ? '0 : hCount + 10'd1;
    v_nxt = !h_end ? vCount : v_end ? '0 : vCount + 10'd1;
  end
  // sync/bright are computed from the next counter values so they never skew against the counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      pix_en     <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      hs         <= 1'b1;
      vs         <= 1'b1;
      br         <= 1'b0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      game_tick  <= 1'b0;
      game_clk   <= 1'b0;
    end else begin
      div_cnt    <= div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
      pix_en     <= div_cnt == DIV_PRE;
      frame_tick <= wrap;
      game_tick  <= wrap && frame_cnt == TF_LAST;
      game_clk   <= game_clk ^ game_tick;
      if (pix_en) begin
        hCount <= h_nxt;
        vCount <= v_nxt;
        hs     <= ~(h_nxt < HS);
        vs     <= ~(v_nxt < VS);
        br     <= h_nxt >= HDS && h_nxt <= HDE && v_nxt >= VDS && v_nxt <= VDE;
      end
      if (wrap) frame_cnt <= frame_cnt == TF_LAST ? '0 : frame_cnt + 8'd1;
    end
  end
`ifdef VGA_PIPE_ALIGN_EN
  logic hs_q, vs_q, br_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      br_q <= 1'b0;
    end else if (pix_en) begin
      hs_q <= hs;
      vs_q <= vs;
      br_q <= br;
    end
  end
  assign hSync  = hs_q;
  assign vSync  = vs_q;
  assign bright = br_q;
`else
  assign hSync  = hs;
  assign vSync  = vs;
  assign bright = br;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default-size instance and a shrunken raster instance.
module tb_vga_timing_gen;
  logic clk, rst;
  logic pix_en0, hSync0, vSync0, bright0, frame_tick0, game_tick0, game_clk0;
  logic [9:0] hCount0, vCount0;
  logic pix_en1, hSync1, vSync1, bright1, frame_tick1, game_tick1, game_clk1;
  logic [9:0] hCount1, vCount1;
  int n_chk = 0;
  int n_fail = 0;

  vga_timing_gen d0 (
    .clk(clk), .rst(rst), .pix_en(pix_en0), .hCount(hCount0), .vCount(vCount0),
    .hSync(hSync0), .vSync(vSync0), .bright(bright0), .frame_tick(frame_tick0),
    .game_tick(game_tick0), .game_clk(game_clk0)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(16),
    .V_TOTAL(10), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(8), .TICK_FRAMES(3)
  ) d1 (
    .clk(clk), .rst(rst), .pix_en(pix_en1), .hCount(hCount1), .vCount(vCount1),
    .hSync(hSync1), .vSync(vSync1), .bright(bright1), .frame_tick(frame_tick1),
    .game_tick(game_tick1), .game_clk(game_clk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t, t0, t1, bad, vline, bcnt, nft, ngt, gt1, gt2, gc_rise, gc_fall, found;
    logic [9:0] ph;
    logic [19:0] first_b, last_b;
    logic p1_t1, p0_t2, p0_t3;
    logic [9:0] h1_t1, h1_t2;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_pix_en", pix_en0, 0);
    chk("rst_hCount", hCount0, 0);
    chk("rst_vCount", vCount0, 0);
    chk("rst_hSync", hSync0, 1);
    chk("rst_vSync", vSync0, 1);
    chk("rst_bright", bright0, 0);
    chk("rst_frame_tick", frame_tick1, 0);
    chk("rst_game_clk", game_clk1, 0);
    rst = 1'b1;
    tick();
    chk("pix_en_clk1", pix_en0, 0);
    tick();
    chk("pix_en_clk2", pix_en0, 0);
    chk("hSync_hold", hSync0, 1);
    tick();
    chk("pix_en_clk4", pix_en0, 1);
    chk("hCount_before_adv", hCount0, 0);
    tick();
    chk("pix_en_pulse_end", pix_en0, 0);
    chk("hCount_first", hCount0, 1);
    chk("vCount_first", vCount0, 0);
    chk("hSync_first", hSync0, 0);
    chk("vSync_first", vSync0, 0);
    // one full default line: sync shape, divider period, wrap timing
    t = 0; t0 = -1; t1 = -1; bad = 0; vline = -1; ph = hCount0;
    while (t1 < 0 && t < 8000) begin
      tick();
      t++;
      if (hSync0 !== (hCount0 >= 10'd96)) bad++;
      if (pix_en0 !== (t % 4 == 3)) bad++;
      if (hCount0 >= 10'd800 || bright0 !== 1'b0) bad++;
      if (ph == 10'd799 && hCount0 == 10'd0) begin
        if (t0 < 0) begin
          t0 = t;
          vline = vCount0;
        end else t1 = t;
      end
      ph = hCount0;
    end
    chk("line_shape", bad, 0);
    chk("line_first_wrap", t0, 3196);
    chk("line_wrap_vCount", vline, 1);
    chk("line_period", t1 - t0, 3200);
    // asynchronous reset mid-line on the small raster
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick();
      if (hCount1 == 10'd10 && vCount1 == 10'd5) found = 1;
    end
    chk("mid_reset_reached", found, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_hCount", hCount1, 0);
    chk("async_vCount", vCount1, 0);
    chk("async_hSync", hSync1, 1);
    chk("async_bright", bright1, 0);
    chk("async_pix_en0", pix_en0, 0);
    chk("async_hCount0", hCount0, 0);
    tick();
    rst = 1'b1;
    // seven frames of the small raster from a clean start
    bad = 0; bcnt = 0; nft = 0; ngt = 0; gt1 = -1; gt2 = -1; gc_rise = -1; gc_fall = -1;
    first_b = '1; last_b = '1;
    p1_t1 = 1'b0; p0_t2 = 1'b1; p0_t3 = 1'b0; h1_t1 = '1; h1_t2 = '1;
    for (t = 1; t <= 2801; t++) begin
      logic gc_prev;
      gc_prev = game_clk1;
      tick();
      if (t == 1) begin
        p1_t1 = pix_en1;
        h1_t1 = hCount1;
      end
      if (t == 2) begin
        h1_t2 = hCount1;
        p0_t2 = pix_en0;
      end
      if (t == 3) p0_t3 = pix_en0;
      if (t >= 2) begin
        if (hSync1 !== (hCount1 >= 10'd3)) bad++;
        if (vSync1 !== (vCount1 >= 10'd2)) bad++;
      end
      if (hCount1 >= 10'd20 || vCount1 >= 10'd10) bad++;
      if (t <= 400 && bright1 && pix_en1) begin
        bcnt++;
        if (first_b == '1) first_b = {hCount1, vCount1};
        last_b = {hCount1, vCount1};
      end
      if (frame_tick1) begin
        nft++;
        if (t % 400 != 0 || hCount1 != 10'd0 || vCount1 != 10'd0) bad++;
      end
      if (game_tick1) begin
        ngt++;
        if (!frame_tick1) bad++;
        if (gt1 < 0) gt1 = t;
        else if (gt2 < 0) gt2 = t;
      end
      if (!gc_prev && game_clk1 && gc_rise < 0) gc_rise = t;
      if (gc_prev && !game_clk1 && gc_fall < 0) gc_fall = t;
    end
    chk("restart_pix_en1", p1_t1, 1);
    chk("restart_hCount1_t1", h1_t1, 0);
    chk("restart_hCount1_t2", h1_t2, 1);
    chk("restart_pix_en0_t2", p0_t2, 0);
    chk("restart_pix_en0_t3", p0_t3, 1);
    chk("frame_shape", bad, 0);
    chk("bright_count", bcnt, 72);
    chk("bright_first", first_b, {10'd5, 10'd3});
    chk("bright_last", last_b, {10'd16, 10'd8});
    chk("frame_ticks", nft, 7);
    chk("game_ticks", ngt, 2);
    chk("game_tick_1", gt1, 1200);
    chk("game_tick_2", gt2, 2400);
    chk("game_clk_rise", gc_rise, 1201);
    chk("game_clk_fall", gc_fall, 2401);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz VGA raster timing that the block/pixel controllers consume: hCount, vCount, bright, plus active-low hSync/vSync to the connector.
- Also produces a slow per-frame game tick that clocks the object/state logic, so positions change at a viewable rate.
- Sits between the board clock and every pixel-generating controller.

Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz pixel rate); legal values >= 2.
- H_TOTAL, 800, clocks per line; hCount range 0..H_TOTAL-1.
- H_SYNC, 96, hSync low while hCount < H_SYNC.
- H_DISP_START, 144, first visible column.
- H_DISP_END, 783, last visible column, inclusive.
- V_TOTAL, 525, lines per frame; vCount range 0..V_TOTAL-1.
- V_SYNC, 2, vSync low while vCount < V_SYNC.
- V_DISP_START, 35, first visible line.
- V_DISP_END, 514, last visible line, inclusive.
- TICK_FRAMES, 1, frames per game_tick; legal range 1..255.

Ports:
- clk  in  1  board clock, 100 MHz.
- rst  in  1  asynchronous reset, active-low.
- pix_en  out  1  one-clk pulse every CLK_DIV clocks; marks a pixel advance.
- hCount  out  10  horizontal counter.
- vCount  out  10  vertical counter.
- hSync  out  1  horizontal sync, active-low.
- vSync  out  1  vertical sync, active-low.
- bright  out  1  high inside the visible window.
- frame_tick  out  1  one-clk pulse at the end of each frame.
- game_tick  out  1  one-clk pulse every TICK_FRAMES frames.
- game_clk  out  1  registered square wave; toggles on every game_tick.

Behaviour:
- Reset (rst low, asynchronous): div_cnt=0, hCount=0, vCount=0, frame counter=0, pix_en=0, hSync=1, vSync=1, bright=0, frame_tick=0, game_tick=0, game_clk=0.
- Reset may assert at any point mid-line; all state returns to the reset values immediately. No partial frame resumes.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered: it is high for exactly the one clk in which div_cnt==CLK_DIV-1.
  - After rst deasserts, the first pix_en is high in clk cycle CLK_DIV.
- Counters advance only on clocks where pix_en is high:
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0.
  - Counters never exceed their TOTAL-1 limit.
- hSync, vSync and bright are registered and update on the same edge as the counters.
  - Each one is a function of the new counter values.
  - Result: the outputs are always consistent with the hCount/vCount values visible in the same cycle (no skew).
  - They hold their reset values until the first pix_en.
- Output rules:
  - hSync = ~(hCount < H_SYNC).
  - vSync = ~(vCount < V_SYNC).
  - bright = (H_DISP_START <= hCount <= H_DISP_END) && (V_DISP_START <= vCount <= V_DISP_END).
- frame_tick:
  - Asserted for one clk on the pix_en edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Never asserted twice within one frame.
- Frame counter and game_tick:
  - The 8-bit frame counter increments on each frame_tick.
  - When it equals TICK_FRAMES-1 and a frame_tick occurs, it wraps to 0 and game_tick pulses in the same clk as frame_tick.
  - With TICK_FRAMES=1, game_tick is identical to frame_tick.
- game_clk toggles on the edge following each game_tick. Its period is 2*TICK_FRAMES frames.
- Rates: one line = H_TOTAL*CLK_DIV clks = 3200; one frame = 1,680,000 clks.

Optional Feature:
- Macro: VGA_PIPE_ALIGN_EN.
- Defined:
  - hSync, vSync and bright are delayed by one extra pixel (one additional pix_en-qualified register stage).
  - This matches downstream controllers that register rgb.
  - Reset values of the delay stage are 1/1/0, so the first valid sync appears one pixel later.
  - hCount, vCount, frame_tick and game_tick are unchanged.
- Undefined: timing exactly as in Behaviour (no extra delay).

Test Plan:
- Reset release, default params -> pix_en first high at clk 4, then every 4 clks; hCount=1 after the first pix_en, vCount=0, hSync=0.
- Run one line -> hSync low for hCount 0..95 and high 96..799; hCount wraps 799->0 with vCount 0->1 on the same edge; line period is 3200 clks.
- Run a full frame -> vSync low only on lines 0..1; bright first high at (144,35) and last high at (783,514); bright is high for exactly 307,200 pix_en cycles per frame; frame_tick pulses once at the (799,524)->(0,0) wrap.
- TICK_FRAMES=3, run 7 frames -> game_tick pulses on frames 3 and 6 only; game_clk 0->1 after frame 3 and 1->0 after frame 6.
- Assert rst low mid-line at hCount=400, vCount=200 -> all outputs at reset values in the same cycle (asynchronously); after release, restart from (0,0) with first pix_en at clk 4.
- Build with VGA_PIPE_ALIGN_EN -> hSync falls one pix_en after hCount reaches 0; bright rises at hCount=145 rather than 144; counters and frame_tick timing are identical to the non-macro build.
